// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
//   sync_fifo_status_t : registered status flag bundle
//   ptr_bits(depth)    : pointer/count width, address bits plus one wrap bit
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } sync_fifo_status_t;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Push/pop handshake bundle for the single-clock FIFO.
//   write_fifo_push, write_data : producer push request and data
//   write_fifo_full             : FIFO full
//   read_fifo_pop               : consumer pop request
//   read_data, read_fifo_empty  : pop data and FIFO empty
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_fifo_push;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_fifo_full;
    logic                  read_fifo_pop;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_fifo_empty;

    modport master (
        output write_fifo_push, write_data, read_fifo_pop,
        input  write_fifo_full, read_data, read_fifo_empty
    );

    modport slave (
        input  write_fifo_push, write_data, read_fifo_pop,
        output write_fifo_full, read_data, read_fifo_empty
    );
endinterface

// File: rtl/sync_fifo_storage.sv
// Register-array storage for the FIFO: one clocked write port and one
// combinational read port. The array is intentionally not reset.
//   clk                    : clock
//   write_en, write_addr,
//   write_data             : write port
//   read_addr, read_data   : asynchronous read port
module sync_fifo_storage
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];
endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
//   clk, reset     : clock, synchronous active-high reset
//   fifo_flush     : synchronous flush (empties FIFO, keeps error flags)
//   fifo           : push/pop handshake (sync_fifo_if.slave)
//   fifo_count     : occupancy 0..FIFO_DEPTH
//   almost_full    : count >= ALMOST_FULL_THR
//   almost_empty   : count <= ALMOST_EMPTY_THR
//   fifo_overflow  : sticky, a push was rejected
//   fifo_underflow : sticky, a pop was rejected
// Build option: SYNC_FIFO_FWFT_EN selects first-word fall-through reads;
// otherwise read_data is registered on each accepted pop.
module sync_fifo_top
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int ALMOST_FULL_THR  = 6,
    parameter int ALMOST_EMPTY_THR = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fifo_flush,
    sync_fifo_if.slave                      fifo,
    output logic [ptr_bits(FIFO_DEPTH)-1:0] fifo_count,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            fifo_overflow,
    output logic                            fifo_underflow
);
    localparam int PW = ptr_bits(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_THR = PW'(ALMOST_FULL_THR);
    localparam logic [PW-1:0] AE_THR = PW'(ALMOST_EMPTY_THR);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_top: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((ALMOST_FULL_THR < 1) || (ALMOST_FULL_THR > FIFO_DEPTH)) begin : g_bad_af
        $error("sync_fifo_top: ALMOST_FULL_THR out of range 1..FIFO_DEPTH");
    end
    if ((ALMOST_EMPTY_THR < 0) || (ALMOST_EMPTY_THR > FIFO_DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_top: ALMOST_EMPTY_THR out of range 0..FIFO_DEPTH-1");
    end

    logic [PW-1:0]              wr_ptr, rd_ptr, count;
    logic [PW-1:0]              wr_ptr_next, rd_ptr_next, count_next;
    sync_fifo_status_t          status, status_next;
    logic                       push_ok, pop_ok, write_en;
    logic [FIFO_DATA_WIDTH-1:0] head;

    always_comb begin
        pop_ok      = fifo.read_fifo_pop && !status.empty;
        // A pop accepted in the same cycle frees the slot the push needs.
        push_ok     = fifo.write_fifo_push && (!status.full || pop_ok);
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (fifo_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count_next = count + PW'(1);
            else if (pop_ok && !push_ok) count_next = count - PW'(1);
        end

        status_next.full         = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                                   (wr_ptr_next[AW] != rd_ptr_next[AW]);
        status_next.empty        = (wr_ptr_next == rd_ptr_next);
        status_next.almost_full  = (count_next >= AF_THR);
        status_next.almost_empty = (count_next <= AE_THR);
        // Flush overrides push/pop, so requests during a flush are not errors.
        status_next.overflow     = status.overflow ||
                                   (!fifo_flush && fifo.write_fifo_push && !push_ok);
        status_next.underflow    = status.underflow ||
                                   (!fifo_flush && fifo.read_fifo_pop && !pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            status <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            status <= status_next;
        end
    end

    assign write_en = push_ok && !fifo_flush && !reset;

    sync_fifo_storage #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_storage (
        .clk        (clk),
        .write_en   (write_en),
        .write_addr (wr_ptr[AW-1:0]),
        .write_data (fifo.write_data),
        .read_addr  (rd_ptr[AW-1:0]),
        .read_data  (head)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo.read_data = status.empty ? '0 : head;
`else
    logic [FIFO_DATA_WIDTH-1:0] read_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= '0;
        end else if (!fifo_flush && pop_ok) begin
            read_data_q <= head;
        end
    end

    assign fifo.read_data = read_data_q;
`endif

    assign fifo.write_fifo_full = status.full;
    assign fifo.read_fifo_empty = status.empty;
    assign fifo_count           = count;
    assign almost_full          = status.almost_full;
    assign almost_empty         = status.almost_empty;
    assign fifo_overflow        = status.overflow;
    assign fifo_underflow       = status.underflow;
endmodule

// File: tb/tb_sync_fifo_top.sv
// Scoreboard bench for sync_fifo_top (DEPTH=8, WIDTH=32, AF=6, AE=2).
// A queue-based reference model advances on each clock edge; a monitor on
// the falling edge compares every status output and popped/head data.
module tb_sync_fifo_top;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_flush;
    logic [3:0] fifo_count;
    logic       almost_full, almost_empty, fifo_overflow, fifo_underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_if #(.DATA_WIDTH(WIDTH)) bus ();

    sync_fifo_top #(
        .FIFO_DATA_WIDTH  (WIDTH),
        .FIFO_DEPTH       (DEPTH),
        .ALMOST_FULL_THR  (AF),
        .ALMOST_EMPTY_THR (AE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_flush     (fifo_flush),
        .fifo           (bus),
        .fifo_count     (fifo_count),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] m_rd;
    logic             m_ovf, m_unf;
    logic             live = 1'b0;

    always @(posedge clk) begin
        logic can_pop, can_push;
        if (reset) begin
            model_q.delete();
            exp_q.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            live  = 1'b1;
        end else if (fifo_flush) begin
            model_q.delete();
        end else if (live) begin
            can_pop  = bus.read_fifo_pop && (model_q.size() > 0);
            can_push = bus.write_fifo_push && ((model_q.size() < DEPTH) || can_pop);
            if (bus.write_fifo_push && !can_push) m_ovf = 1'b1;
            if (bus.read_fifo_pop && !can_pop)    m_unf = 1'b1;
            if (can_pop) begin
                m_rd = model_q.pop_front();
                exp_q.push_back(m_rd);
            end
            if (can_push) model_q.push_back(bus.write_data);
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model after every edge
    always @(negedge clk) begin
        if (live) begin
            chk("count",        32'(fifo_count),          32'(model_q.size()));
            chk("full",         32'(bus.write_fifo_full), 32'(model_q.size() == DEPTH));
            chk("empty",        32'(bus.read_fifo_empty), 32'(model_q.size() == 0));
            chk("almost_full",  32'(almost_full),         32'(model_q.size() >= AF));
            chk("almost_empty", 32'(almost_empty),        32'(model_q.size() <= AE));
            chk("overflow",     32'(fifo_overflow),       32'(m_ovf));
            chk("underflow",    32'(fifo_underflow),      32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            if (!bus.read_fifo_empty && model_q.size() > 0)
                chk("fwft_head", bus.read_data, model_q[0]);
            exp_q.delete();
`else
            if (exp_q.size() > 0) chk("pop_data", bus.read_data, exp_q.pop_front());
            else                  chk("rd_hold",  bus.read_data, m_rd);
`endif
        end
    end

    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic o,
                        input logic f, input logic r);
        bus.write_fifo_push = p;
        bus.write_data      = d;
        bus.read_fifo_pop   = o;
        fifo_flush          = f;
        reset               = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        fifo_flush          = 1'b0;
        bus.write_fifo_push = 1'b0;
        bus.write_data      = '0;
        bus.read_fifo_pop   = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(1, 32'(i), 0, 0, 0);
        // Push into full: overflow, data dropped
        step(1, 32'hDEAD, 0, 0, 0);
        // Push + pop while full: accepted, count unchanged
        step(1, 32'hBEEF, 1, 0, 0);
        // Drain: 1..7 then BEEF, then one extra pop for underflow
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0, 0);
        // Pop + push while empty: push accepted, pop rejected
        step(1, 32'h55, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Three pushes then flush
        for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Refill partially, then reset alongside a push
        for (int i = 0; i < 2; i++) step(1, 32'h200 + 32'(i), 0, 0, 0);
        step(1, 32'h777, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), 1'b0);
        end
        // Drain whatever is left
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
